// File: rtl/trace_pkg.sv
// Shared types for the commit-trace recorder: entry kinds, default-width entry layout
// and the retire-kind classifier.
package trace_pkg;

  typedef enum logic [2:0] {
    KindNop  = 3'd0,
    KindReg  = 3'd1,
    KindLd   = 3'd2,
    KindSt   = 3'd3,
    KindStu  = 3'd4,
    KindHalt = 3'd5
  } trace_kind_e;

  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefRegW  = 3;
  localparam int unsigned DefCntW  = 32;

  // Field order matches the packed layout of rd_entry in commit_trace_buffer.
  typedef struct packed {
    trace_kind_e           kind;
    logic [DefCntW-1:0]    inum;
    logic [DefAddrW-1:0]   pc;
    logic [DefRegW-1:0]    reg_idx;
    logic [DefDataW-1:0]   reg_value;
    logic [DefAddrW-1:0]   mem_addr;
    logic [DefDataW-1:0]   mem_data;
  } trace_entry_t;

  function automatic trace_kind_e decode_kind(input logic halt, input logic reg_write,
                                              input logic mem_read, input logic mem_write);
    if (halt)                   return KindHalt;
    if (reg_write && mem_write) return KindStu;
    if (reg_write && mem_read)  return KindLd;
    if (reg_write)              return KindReg;
    if (mem_write)              return KindSt;
    return KindNop;
  endfunction

  function automatic logic kind_has_reg(input trace_kind_e kind);
    return kind inside {KindReg, KindLd, KindStu};
  endfunction

  function automatic logic kind_has_mem_addr(input trace_kind_e kind);
    return kind inside {KindLd, KindSt, KindStu};
  endfunction

  function automatic logic kind_has_mem_data(input trace_kind_e kind);
    return kind inside {KindSt, KindStu};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace buffer: one push and one pop per cycle, with either drop-new or
// overwrite-oldest behaviour when full.
module trace_fifo #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned WRAP_MODE = 0,
  parameter type         entry_t   = logic,
  localparam int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_push,
  input  entry_t         i_data,
  input  logic           i_pop,
  output logic           o_valid,
  output entry_t         o_data,
  output logic [PTR_W:0] o_count,
  output logic           o_drop,
  output logic           o_overwrite
);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (PTR_W + 1)'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;

  // A full buffer still accepts a push when a pop frees a slot in the same cycle.
  assign w_wr        = i_push & (~w_full | w_pop | (WRAP_MODE != 0));
  assign o_overwrite = i_push & w_full & ~w_pop & (WRAP_MODE != 0);
  assign o_drop      = i_push & w_full & ~w_pop & (WRAP_MODE == 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop | o_overwrite) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= r_count + (PTR_W + 1)'(w_wr & ~o_overwrite) - (PTR_W + 1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  assign o_valid = ~w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace recorder: classifies retiring instructions, numbers them and buffers them,
// alongside cycle/instruction/drop counters, a commit watchdog and sticky flags.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned REG_W       = 3,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WRAP_MODE   = 0,
  parameter int unsigned CAPTURE_NOP = 1,
  parameter int unsigned WDOG_LIMIT  = 10000,
  parameter int unsigned CNT_W       = 32,
  localparam int unsigned ENTRY_W    = 3 + CNT_W + 2 * ADDR_W + REG_W + 2 * DATA_W,
  localparam int unsigned OCC_W      = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_commit_valid,
  input  logic [ADDR_W-1:0]  i_commit_pc,
  input  logic               i_reg_write,
  input  logic [REG_W-1:0]   i_reg_idx,
  input  logic [DATA_W-1:0]  i_reg_value,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic [ADDR_W-1:0]  i_mem_addr,
  input  logic [DATA_W-1:0]  i_mem_data,
  input  logic               i_halt,
  input  logic               i_err_in,
  output logic               o_rd_valid,
  input  logic               i_rd_ready,
  output logic [ENTRY_W-1:0] o_rd_entry,
  output logic [OCC_W-1:0]   o_occupancy,
  output logic [CNT_W-1:0]   o_inst_count,
  output logic [CNT_W-1:0]   o_cycle_count,
  output logic [CNT_W-1:0]   o_dropped_count,
  output logic               o_overflow,
  output logic               o_done,
  output logic               o_err
);

  typedef struct packed {
    trace_kind_e         kind;
    logic [CNT_W-1:0]    inum;
    logic [ADDR_W-1:0]   pc;
    logic [REG_W-1:0]    reg_idx;
    logic [DATA_W-1:0]   reg_value;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_data;
  } entry_t;

  entry_t      w_entry;
  entry_t      w_rd_entry;
  trace_kind_e w_kind;

  logic w_running;
  logic w_active;
  logic w_push;
  logic w_pop;
  logic w_drop;
  logic w_overwrite;
  logic w_wdog_fire;

  logic [CNT_W-1:0] r_inst_count;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_dropped_count;
  logic [CNT_W-1:0] r_wdog;
  logic [CNT_W-1:0] w_wdog_inc;
  logic             r_overflow;
  logic             r_done;
  logic             r_err;

  assign w_running = ~r_done & ~r_err;
  assign w_active  = i_commit_valid & w_running;
  assign w_kind    = decode_kind(i_halt, i_reg_write, i_mem_read, i_mem_write);
  assign w_push    = w_active & ((w_kind != KindNop) | (CAPTURE_NOP != 0));
  assign w_pop     = o_rd_valid & i_rd_ready;

  // Fields that do not belong to the entry's kind are zeroed so traces compare cleanly.
  always_comb begin
    w_entry      = '0;
    w_entry.kind = w_kind;
    w_entry.inum = r_inst_count;
    w_entry.pc   = i_commit_pc;
    if (kind_has_reg(w_kind)) begin
      w_entry.reg_idx   = i_reg_idx;
      w_entry.reg_value = i_reg_value;
    end
    if (kind_has_mem_addr(w_kind)) begin
      w_entry.mem_addr = i_mem_addr;
    end
    if (kind_has_mem_data(w_kind)) begin
      w_entry.mem_data = i_mem_data;
    end
  end

  trace_fifo #(
    .DEPTH     (DEPTH),
    .WRAP_MODE (WRAP_MODE),
    .entry_t   (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_data      (w_entry),
    .i_pop       (w_pop),
    .o_valid     (o_rd_valid),
    .o_data      (w_rd_entry),
    .o_count     (o_occupancy),
    .o_drop      (w_drop),
    .o_overwrite (w_overwrite)
  );

  // Watchdog counts consecutive idle cycles; the limit-th idle cycle raises err.
  assign w_wdog_inc  = r_wdog + CNT_W'(1);
  assign w_wdog_fire = (WDOG_LIMIT != 0) & w_running & ~i_commit_valid &
                       (w_wdog_inc >= CNT_W'(WDOG_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_count    <= '0;
      r_cycle_count   <= '0;
      r_dropped_count <= '0;
      r_wdog          <= '0;
      r_overflow      <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      if (w_running) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
      if (w_active) begin
        r_inst_count <= r_inst_count + CNT_W'(1);
      end
      if (w_drop | w_overwrite) begin
        r_dropped_count <= r_dropped_count + CNT_W'(1);
        r_overflow      <= 1'b1;
      end
      if (w_active & i_halt) begin
        r_done <= 1'b1;
      end
      if (i_err_in | w_wdog_fire) begin
        r_err <= 1'b1;
      end
      if (!w_running || i_commit_valid) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= w_wdog_inc;
      end
    end
  end

  assign o_rd_entry      = w_rd_entry;
  assign o_inst_count    = r_inst_count;
  assign o_cycle_count   = r_cycle_count;
  assign o_dropped_count = r_dropped_count;
  assign o_overflow      = r_overflow;
  assign o_done          = r_done;
  assign o_err           = r_err;

endmodule
